// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns mnemonic/field requests into 32-bit words
// with a one-entry ready/valid output register, an address counter and word/error counters.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        out_illegal,
  output logic [15:0] word_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    FMT_R, FMT_SHIFT, FMT_JR, FMT_I, FMT_LUI, FMT_J, FMT_ILL
  } fmt_e;

  fmt_e        fmt;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] encWord;
  logic        encIllegal;

  logic        valid_q,   valid_d;
  logic [31:0] word_q,    word_d;
  logic [31:0] outAddr_q, outAddr_d;
  logic        illegal_q, illegal_d;
  logic [31:0] curAddr_q, curAddr_d;
  logic [15:0] wordCnt_q, wordCnt_d;
  logic [7:0]  errCnt_q,  errCnt_d;

  logic inHs;
  logic outHs;

  always_comb begin
    fmt    = FMT_ILL;
    opcode = 6'd0;
    funct  = 6'd0;
    case (in_mnem)
      5'd0:  begin fmt = FMT_R;     funct = 6'd32; end
      5'd1:  begin fmt = FMT_R;     funct = 6'd34; end
      5'd2:  begin fmt = FMT_R;     funct = 6'd36; end
      5'd3:  begin fmt = FMT_R;     funct = 6'd37; end
      5'd4:  begin fmt = FMT_R;     funct = 6'd38; end
      5'd5:  begin fmt = FMT_R;     funct = 6'd39; end
      5'd6:  begin fmt = FMT_R;     funct = 6'd42; end
      5'd7:  begin fmt = FMT_SHIFT; funct = 6'd0;  end
      5'd8:  begin fmt = FMT_SHIFT; funct = 6'd2;  end
      5'd9:  begin fmt = FMT_SHIFT; funct = 6'd3;  end
      5'd10: begin fmt = FMT_JR;    funct = 6'd8;  end
      5'd11: begin fmt = FMT_I;     opcode = 6'd8;  end
      5'd12: begin fmt = FMT_I;     opcode = 6'd12; end
      5'd13: begin fmt = FMT_I;     opcode = 6'd13; end
      5'd14: begin fmt = FMT_I;     opcode = 6'd14; end
      5'd15: begin fmt = FMT_I;     opcode = 6'd10; end
      5'd16: begin fmt = FMT_LUI;   opcode = 6'd15; end
      5'd17: begin fmt = FMT_I;     opcode = 6'd35; end
      5'd18: begin fmt = FMT_I;     opcode = 6'd43; end
      5'd19: begin fmt = FMT_I;     opcode = 6'd32; end
      5'd20: begin fmt = FMT_I;     opcode = 6'd33; end
      5'd21: begin fmt = FMT_I;     opcode = 6'd40; end
      5'd22: begin fmt = FMT_I;     opcode = 6'd41; end
      5'd23: begin fmt = FMT_I;     opcode = 6'd4;  end
      5'd24: begin fmt = FMT_I;     opcode = 6'd5;  end
      5'd25: begin fmt = FMT_J;     opcode = 6'd2;  end
      5'd26: begin fmt = FMT_J;     opcode = 6'd3;  end
      default: fmt = FMT_ILL;
    endcase
  end

  // Only the fields belonging to the selected format reach the word; the rest are dropped.
  always_comb begin
    encWord    = 32'h0000_0000;
    encIllegal = 1'b0;
    case (fmt)
      FMT_R:     encWord = {6'd0, in_rs, in_rt, in_rd, 5'd0, funct};
      FMT_SHIFT: encWord = {6'd0, 5'd0, in_rt, in_rd, in_shamt, funct};
      FMT_JR:    encWord = {6'd0, in_rs, 5'd0, 5'd0, 5'd0, funct};
      FMT_I:     encWord = {opcode, in_rs, in_rt, in_imm};
      FMT_LUI:   encWord = {opcode, 5'd0, in_rt, in_imm};
      FMT_J:     encWord = {opcode, in_target};
      default:   encIllegal = 1'b1;
    endcase
  end

  assign in_ready = rst_n && !start && (!valid_q || out_ready);
  assign inHs     = in_valid && in_ready;
  assign outHs    = valid_q && out_ready;

  // start wins over both handshakes: the held word is discarded uncounted.
  always_comb begin
    valid_d   = valid_q;
    word_d    = word_q;
    outAddr_d = outAddr_q;
    illegal_d = illegal_q;
    curAddr_d = curAddr_q;
    wordCnt_d = wordCnt_q;
    errCnt_d  = errCnt_q;
    if (start) begin
      valid_d   = 1'b0;
      curAddr_d = base_addr;
      wordCnt_d = 16'd0;
      errCnt_d  = 8'd0;
    end else begin
      if (outHs) begin
        valid_d   = 1'b0;
        wordCnt_d = wordCnt_q + 16'd1;
        if (illegal_q && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
      end
      if (inHs) begin
        valid_d   = 1'b1;
        word_d    = encWord;
        illegal_d = encIllegal;
        outAddr_d = curAddr_q;
        curAddr_d = curAddr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      word_q    <= 32'h0000_0000;
      outAddr_q <= 32'h0000_0000;
      illegal_q <= 1'b0;
      curAddr_q <= 32'h0000_0000;
      wordCnt_q <= 16'd0;
      errCnt_q  <= 8'd0;
    end else begin
      valid_q   <= valid_d;
      word_q    <= word_d;
      outAddr_q <= outAddr_d;
      illegal_q <= illegal_d;
      curAddr_q <= curAddr_d;
      wordCnt_q <= wordCnt_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_word    = word_q;
  assign out_addr    = outAddr_q;
  assign out_illegal = illegal_q;
  assign word_count  = wordCnt_q;
  assign err_count   = errCnt_q;

endmodule
